// File: rtl/biriscv_divider_param_pkg.sv
// Shared definitions for the iterative RV32M/RV64M divider: the M-extension
// divide opcode match/mask constants, the decoded operation class and small
// decode helpers.
package biriscv_divider_param_pkg;

    // RV32M divide-family encodings (funct7=0000001, OP major opcode)
    localparam logic [31:0] INST_DIV       = 32'h02004033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_DIVU      = 32'h02005033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_REM       = 32'h02006033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_REMU      = 32'h02007033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

    // Operation class; also used as the cache tag for the opcode
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_REM  = 3'd3,
        OP_REMU = 3'd4
    } div_op_e;

    function automatic div_op_e decode_m_op(input logic [31:0] inst);
        div_op_e op;
        op = OP_NONE;
        if ((inst & INST_DIV_MASK) == INST_DIV)        op = OP_DIV;
        else if ((inst & INST_DIVU_MASK) == INST_DIVU) op = OP_DIVU;
        else if ((inst & INST_REM_MASK) == INST_REM)   op = OP_REM;
        else if ((inst & INST_REMU_MASK) == INST_REMU) op = OP_REMU;
        return op;
    endfunction

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/biriscv_divider_param_div_step.sv
// One restoring division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep the
// difference when it does not borrow and shift the quotient bit in.
module biriscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Compare/subtract/shift; quo_i doubles as the dividend shift register
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/biriscv_divider_param.sv
// Iterative DIV/DIVU/REM/REMU unit. IDLE accepts an instruction, CALC retires
// BITS_PER_CYCLE quotient bits per cycle, DONE strobes the result for one
// cycle. Divide-by-zero, signed overflow and last-result cache hits skip CALC.
// Handshake: an instruction is taken in the cycle opcode_valid_i=1, the opcode
// is a divide-family op, ready_o=1 and flush_i=0; the result appears as a
// single-cycle writeback_valid_o pulse with no back-pressure.
module biriscv_divider_param
    import biriscv_divider_param_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int RESULT_CACHE   = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            writeback_valid_o,
    output logic [XLEN-1:0] writeback_value_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int              N_ITER   = XLEN / BITS_PER_CYCLE;
    localparam int              CW       = $clog2(N_ITER + 1);
    localparam logic [CW-1:0]   N_LOAD   = CW'(N_ITER);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            rem_sel_q, rem_sel_d;
    div_op_e         op_q, op_d;
    logic [XLEN-1:0] ra_q, ra_d;
    logic [XLEN-1:0] rb_q, rb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cache_valid_q, cache_valid_d;
    div_op_e         cache_op_q, cache_op_d;
    logic [XLEN-1:0] cache_ra_q, cache_ra_d;
    logic [XLEN-1:0] cache_rb_q, cache_rb_d;
    logic [XLEN-1:0] cache_result_q, cache_result_d;

    div_op_e         in_op;
    logic            in_signed;
    logic            in_rem;
    logic            in_a_neg;
    logic            in_b_neg;
    logic            in_div_zero;
    logic            in_overflow;
    logic            in_cache_hit;
    logic            accept;
    logic            wb_valid;

    logic [XLEN-1:0] calc_quo;
    logic [XLEN-1:0] calc_rem;
    logic [XLEN-1:0] calc_result;

    // Restoring step chain: stage 0 is fed from the registers
    logic [XLEN-1:0] chain_rem [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] chain_quo [BITS_PER_CYCLE+1];

    assign chain_rem[0] = rem_q;
    assign chain_quo[0] = quo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        biriscv_div_step #(
            .XLEN(XLEN)
        ) u_step (
            .rem_i     (chain_rem[g]),
            .quo_i     (chain_quo[g]),
            .divisor_i (divisor_q),
            .rem_o     (chain_rem[g+1]),
            .quo_o     (chain_quo[g+1])
        );
    end

    // Decode the offered instruction and classify early-out cases
    always_comb begin
        in_op        = decode_m_op(opcode_opcode_i);
        in_signed    = op_is_signed(in_op);
        in_rem       = op_is_rem(in_op);
        in_a_neg     = in_signed & opcode_ra_operand_i[XLEN-1];
        in_b_neg     = in_signed & opcode_rb_operand_i[XLEN-1];
        in_div_zero  = (opcode_rb_operand_i == '0);
        in_overflow  = in_signed && (opcode_ra_operand_i == MOST_NEG) &&
                       (opcode_rb_operand_i == '1);
        in_cache_hit = (RESULT_CACHE != 0) && cache_valid_q &&
                       (cache_op_q == in_op) &&
                       (cache_ra_q == opcode_ra_operand_i) &&
                       (cache_rb_q == opcode_rb_operand_i);
        accept       = opcode_valid_i && (in_op != OP_NONE) &&
                       (state_q == ST_IDLE) && !flush_i;
    end

    // Sign-correct the final iteration's magnitudes into the architectural result
    always_comb begin
        calc_quo    = neg_quo_q ? ('0 - chain_quo[BITS_PER_CYCLE]) : chain_quo[BITS_PER_CYCLE];
        calc_rem    = neg_rem_q ? ('0 - chain_rem[BITS_PER_CYCLE]) : chain_rem[BITS_PER_CYCLE];
        calc_result = rem_sel_q ? calc_rem : calc_quo;
    end

    // Next-state, datapath and cache update
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        divisor_d      = divisor_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        rem_sel_d      = rem_sel_q;
        op_d           = op_q;
        ra_d           = ra_q;
        rb_d           = rb_q;
        result_d       = result_q;
        cache_valid_d  = cache_valid_q;
        cache_op_d     = cache_op_q;
        cache_ra_d     = cache_ra_q;
        cache_rb_d     = cache_rb_q;
        cache_result_d = cache_result_q;
        wb_valid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = in_op;
                    ra_d      = opcode_ra_operand_i;
                    rb_d      = opcode_rb_operand_i;
                    rem_sel_d = in_rem;
                    if (in_cache_hit) begin
                        result_d = cache_result_q;
                        state_d  = ST_DONE;
                    end else if (in_div_zero) begin
                        result_d = in_rem ? opcode_ra_operand_i : '1;
                        state_d  = ST_DONE;
                    end else if (in_overflow) begin
                        result_d = in_rem ? '0 : opcode_ra_operand_i;
                        state_d  = ST_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = in_a_neg ? ('0 - opcode_ra_operand_i) : opcode_ra_operand_i;
                        divisor_d = in_b_neg ? ('0 - opcode_rb_operand_i) : opcode_rb_operand_i;
                        neg_quo_d = in_a_neg ^ in_b_neg;
                        neg_rem_d = in_a_neg;
                        count_d   = N_LOAD;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = chain_rem[BITS_PER_CYCLE];
                    quo_d   = chain_quo[BITS_PER_CYCLE];
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        result_d = calc_result;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    wb_valid       = 1'b1;
                    cache_valid_d  = 1'b1;
                    cache_op_d     = op_q;
                    cache_ra_d     = ra_q;
                    cache_rb_d     = rb_q;
                    cache_result_d = result_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A kill may have squashed the producer of the cached value
        if (flush_i) begin
            cache_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            divisor_q      <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            rem_sel_q      <= 1'b0;
            op_q           <= OP_NONE;
            ra_q           <= '0;
            rb_q           <= '0;
            result_q       <= '0;
            cache_valid_q  <= 1'b0;
            cache_op_q     <= OP_NONE;
            cache_ra_q     <= '0;
            cache_rb_q     <= '0;
            cache_result_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            divisor_q      <= divisor_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            rem_sel_q      <= rem_sel_d;
            op_q           <= op_d;
            ra_q           <= ra_d;
            rb_q           <= rb_d;
            result_q       <= result_d;
            cache_valid_q  <= cache_valid_d;
            cache_op_q     <= cache_op_d;
            cache_ra_q     <= cache_ra_d;
            cache_rb_q     <= cache_rb_d;
            cache_result_q <= cache_result_d;
        end
    end

    assign ready_o           = (state_q == ST_IDLE);
    assign busy_o            = (state_q != ST_IDLE);
    assign writeback_valid_o = wb_valid;
    assign writeback_value_o = result_q;

endmodule

// File: tb/tb_biriscv_divider_param.sv
// Bench for biriscv_divider_param (XLEN=32, BITS_PER_CYCLE=2). A behavioural
// model predicts each result with plain arithmetic and its writeback cycle
// from the early-out and cache rules; a per-cycle compare process checks the
// strobe, value, ready and busy against it.
module tb_biriscv_divider_param;

    localparam int XLEN   = 32;
    localparam int N_ITER = 16;
    localparam int K_DIV  = 0;
    localparam int K_DIVU = 1;
    localparam int K_REM  = 2;
    localparam int K_REMU = 3;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            opcode_valid_i = 1'b0;
    logic [31:0]     opcode_opcode_i = '0;
    logic [XLEN-1:0] opcode_ra_operand_i = '0;
    logic [XLEN-1:0] opcode_rb_operand_i = '0;
    logic            flush_i = 1'b0;
    logic            ready_o;
    logic            busy_o;
    logic            writeback_valid_o;
    logic [XLEN-1:0] writeback_value_o;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int          t;
        int          due;
        logic [31:0] val;
        int          k;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];

    logic        m_cache_valid = 1'b0;
    int          m_cache_k = 0;
    logic [31:0] m_cache_a = '0;
    logic [31:0] m_cache_b = '0;

    biriscv_divider_param #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (2),
        .RESULT_CACHE   (1)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_opcode_i     (opcode_opcode_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .flush_i             (flush_i),
        .ready_o             (ready_o),
        .busy_o              (busy_o),
        .writeback_valid_o   (writeback_valid_o),
        .writeback_value_o   (writeback_value_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic is_signed_k(input int k);
        return (k == K_DIV) || (k == K_REM);
    endfunction

    function automatic logic [31:0] ref_result(input int k, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return (k == K_REM || k == K_REMU) ? a : 32'hffffffff;
        case (k)
            K_DIV:   r = sa / sb;
            K_REM:   r = sa % sb;
            K_DIVU:  r = longint'(a) / longint'(b);
            default: r = longint'(a) % longint'(b);
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_latency(input int k, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (is_signed_k(k) && a == 32'h80000000 && b == 32'hffffffff) return 1;
        if (m_cache_valid && k == m_cache_k && a == m_cache_a && b == m_cache_b) return 1;
        return N_ITER + 1;
    endfunction

    function automatic logic [31:0] enc(input int k);
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
        rd  = 5'($urandom_range(1, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'(4 + k);
        return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic exp_now;
        logic busy_exp;
        if (rst_ni) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("wb_missed", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            exp_now  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            busy_exp = (exp_q.size() > 0) && (cyc > exp_q[0].t) && (cyc <= exp_q[0].due);
            check("wb_valid", 32'(writeback_valid_o), 32'(exp_now));
            if (!flush_i) begin
                check("busy", 32'(busy_o), 32'(busy_exp));
                check("ready", 32'(ready_o), 32'(!busy_exp));
            end
            if (exp_now) begin
                check("wb_value", writeback_value_o, exp_q[0].val);
                m_cache_valid = 1'b1;
                m_cache_k     = exp_q[0].k;
                m_cache_a     = exp_q[0].a;
                m_cache_b     = exp_q[0].b;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step_cycle();
    endtask

    task automatic issue(input string name, input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_val, input int exp_lat, output int t_acc);
        int   guard;
        exp_t e;
        guard = 0;
        while (!ready_o && guard < 64) begin
            step_cycle();
            guard++;
        end
        t_acc = cyc;
        check({name, "_ready"}, 32'(ready_o), 32'd1);
        if (!ready_o) return;
        e.t   = cyc;
        e.val = ref_result(k, a, b);
        e.due = cyc + ref_latency(k, a, b);
        e.k   = k;
        e.a   = a;
        e.b   = b;
        check({name, "_model_val"}, e.val, exp_val);
        check({name, "_model_lat"}, 32'(e.due - e.t), 32'(exp_lat));
        exp_q.push_back(e);
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = enc(k);
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
        step_cycle();
        opcode_valid_i      = 1'b0;
        opcode_ra_operand_i = '0;
        opcode_rb_operand_i = '0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 64) begin
            step_cycle();
            guard++;
        end
        step_cycle();
    endtask

    task automatic run(input string name, input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_val, input int exp_lat);
        int t;
        issue(name, k, a, b, exp_val, exp_lat, t);
        wait_idle();
    endtask

    task automatic flush_cycle();
        flush_i = 1'b1;
        m_cache_valid = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].t < cyc) void'(exp_q.pop_front());
        step_cycle();
        flush_i = 1'b0;
    endtask

    task automatic drive_non_m(input logic [31:0] inst);
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = inst;
        opcode_ra_operand_i = 32'd100;
        opcode_rb_operand_i = 32'd7;
        step_cycle();
        opcode_valid_i = 1'b0;
        step_cycle();
        check("non_m_ignored_ready", 32'(ready_o), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_wb_valid", 32'(writeback_valid_o), 32'd0);
        check("rst_wb_value", writeback_value_o, 32'd0);
        rst_ni = 1'b1;
        step_cycle();

        // Full-length iterations
        run("divu_100_7", K_DIVU, 32'd100, 32'd7, 32'd14, 17);
        run("remu_100_7", K_REMU, 32'd100, 32'd7, 32'd2, 17);
        run("rem_m7_2", K_REM, 32'hfffffff9, 32'd2, 32'hffffffff, 17);
        run("div_m7_2", K_DIV, 32'hfffffff9, 32'd2, 32'hfffffffd, 17);

        // Early-outs
        run("div_5_0", K_DIV, 32'd5, 32'd0, 32'hffffffff, 1);
        run("remu_5_0", K_REMU, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf", K_DIV, 32'h80000000, 32'hffffffff, 32'h80000000, 1);
        run("rem_ovf", K_REM, 32'h80000000, 32'hffffffff, 32'd0, 1);

        // Result cache hit, then miss after an idle flush
        run("divu_c1", K_DIVU, 32'd100, 32'd7, 32'd14, 17);
        run("divu_c2", K_DIVU, 32'd100, 32'd7, 32'd14, 1);
        flush_cycle();
        run("divu_c3", K_DIVU, 32'd100, 32'd7, 32'd14, 17);

        // Assorted magnitudes and sign combinations
        run("divu_max_1", K_DIVU, 32'hffffffff, 32'd1, 32'hffffffff, 17);
        run("div_min_2", K_DIV, 32'h80000000, 32'd2, 32'hc0000000, 17);
        run("rem_7_m2", K_REM, 32'd7, 32'hfffffffe, 32'd1, 17);
        run("div_m7_m2", K_DIV, 32'hfffffff9, 32'hfffffffe, 32'd3, 17);
        run("divu_5_10", K_DIVU, 32'd5, 32'd10, 32'd0, 17);

        // flush together with a valid opcode: not taken, cache dropped
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = enc(K_DIVU);
        opcode_ra_operand_i = 32'd5;
        opcode_rb_operand_i = 32'd10;
        flush_cycle();
        opcode_valid_i = 1'b0;
        step_cycle();
        check("flush_valid_ready", 32'(ready_o), 32'd1);
        run("divu_5_10_again", K_DIVU, 32'd5, 32'd10, 32'd0, 17);

        // Non divide opcodes are ignored
        drive_non_m(32'h00a58533);
        drive_non_m(32'h06004033);

        // Kill during CALC
        issue("divu_1000_3_k", K_DIVU, 32'd1000, 32'd3, 32'd333, 17, t);
        wait_until(t + 5);
        flush_cycle();
        check("calc_flush_ready", 32'(ready_o), 32'd1);
        check("calc_flush_busy", 32'(busy_o), 32'd0);
        run("divu_1000_3", K_DIVU, 32'd1000, 32'd3, 32'd333, 17);

        // Kill in DONE: strobe suppressed, cache not updated
        issue("divu_50_5_k", K_DIVU, 32'd50, 32'd5, 32'd10, 17, t);
        wait_until(t + 17);
        flush_cycle();
        check("done_flush_ready", 32'(ready_o), 32'd1);
        run("divu_50_5", K_DIVU, 32'd50, 32'd5, 32'd10, 17);

        // Asynchronous reset in the middle of an operation
        issue("divu_77_7_r", K_DIVU, 32'd77, 32'd7, 32'd11, 17, t);
        wait_until(t + 8);
        rst_ni = 1'b0;
        exp_q.delete();
        m_cache_valid = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_wb_valid", 32'(writeback_valid_o), 32'd0);
        check("midrst_wb_value", writeback_value_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        step_cycle();
        run("divu_77_7", K_DIVU, 32'd77, 32'd7, 32'd11, 17);
        run("divu_77_7_hit", K_DIVU, 32'd77, 32'd7, 32'd11, 1);

        repeat (3) step_cycle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/biriscv_divider_param.md
BIRISCV_DIVIDER_PARAM -- requirements
Module: biriscv_divider_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are 32 and 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, meaning quotient bits retired per iteration cycle; legal values are 1, 2 and 4, and XLEN mod BITS_PER_CYCLE = 0.
REQ-003 SHALL have parameter RESULT_CACHE, default 1, meaning the last-result cache is enabled when 1.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 opcode_valid_i  in  1  instruction offered this cycle.
REQ-007 opcode_opcode_i  in  32  instruction word; decoded for DIV/DIVU/REM/REMU.
REQ-008 opcode_ra_operand_i  in  XLEN  dividend.
REQ-009 opcode_rb_operand_i  in  XLEN  divisor.
REQ-010 flush_i  in  1  pipeline kill; aborts any operation in flight.
REQ-011 ready_o  out  1  block can accept an instruction this cycle.
REQ-012 busy_o  out  1  operation accepted and result not yet written back.
REQ-013 writeback_valid_o  out  1  one-cycle result strobe.
REQ-014 writeback_value_o  out  XLEN  result; valid while writeback_valid_o=1.

Function
REQ-015 SHALL accept an instruction when opcode_valid_i=1, the opcode decodes as DIV/DIVU/REM/REMU, ready_o=1 and flush_i=0; non-M opcodes are ignored.
REQ-016 SHALL implement states IDLE, CALC, DONE; ready_o=1 only in IDLE; busy_o=1 in CALC and DONE.
REQ-017 Accept in cycle T: IDLE->CALC, iteration counter loaded with N=XLEN/BITS_PER_CYCLE.
REQ-018 Each CALC cycle SHALL perform BITS_PER_CYCLE restoring steps on unsigned magnitudes and decrement the counter; the last iteration moves CALC->DONE.
REQ-019 SHALL assert writeback_valid_o for exactly one cycle, in DONE, at cycle T+N+1; DONE->IDLE unconditionally.
REQ-020 Signed ops SHALL divide magnitudes; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-021 Divide by zero SHALL early-out: IDLE->DONE, valid at T+1; quotient all-ones, remainder = dividend.
REQ-022 Signed overflow (dividend = most-negative, divisor = -1) SHALL early-out at T+1: quotient = dividend, remainder 0.
REQ-023 With RESULT_CACHE=1, an accepted op whose opcode class and both operands equal the last completed op SHALL early-out at T+1 with the stored result.
REQ-024 flush_i=1 in CALC SHALL return to IDLE next cycle with no writeback; flush_i=1 in DONE SHALL force writeback_valid_o=0 that cycle.
REQ-025 flush_i SHALL invalidate the result cache; flush_i simultaneous with opcode_valid_i SHALL not accept.
REQ-026 The cache SHALL update only on a completed, unflushed writeback.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, ready_o=1, busy_o=0, writeback_valid_o=0, writeback_value_o=0, cache invalid, counter 0, including mid-operation.

Structure
REQ-028 Opcode match/mask constants SHALL come from the shared biriscv_defs_rv32m.v definitions; state encoding SHALL be local parameters.
REQ-029 One restoring step (compare, subtract, shift, quotient bit) SHALL be sub-module biriscv_div_step, instantiated BITS_PER_CYCLE times in a chain.

Verification (XLEN=32, BITS_PER_CYCLE=2, N=16)
REQ-030 DIVU 100/7 accepted at T -> writeback_valid_o at T+17, value 14; REMU same operands -> 2.
REQ-031 REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIV same -> 0xFFFFFFFD; both at T+17.
REQ-032 DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5 at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1, REM -> 0.
REQ-033 DIVU 100/7 then identical DIVU 100/7 -> second result 14 at T+1; insert flush_i between them -> second takes T+17.
REQ-034 flush_i at T+5 of a DIVU -> no writeback, ready_o=1 at T+6; rst_ni low at T+8 of another op -> all outputs at reset values immediately.
